// File: rtl/trace_serialiser.sv
// trace_serialiser
//   Terminal stage of the trace pipeline. Each completed trace element is
//   captured on a one-cycle strobe, tagged with an 8-bit sequence number and
//   counter[7:0], and buffered in a small FIFO. It is then emitted as a framed
//   stream of 32-bit words: one header word followed by W payload words.
//
//   Optional build macro TRACE_SERIAL_CHECKSUM_EN appends a checksum word to
//   each packet. The checksum is the XOR of the header and all payload words.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   counter         global cycle counter (only bits [7:0] are captured)
//   elem_valid      one-cycle strobe: elem_i holds a new element
//   elem_i          packed trace element
//   out_valid       out_data/out_last are valid
//   out_ready       sink accepts the current word
//   out_data        stream word
//   out_last        final word of the current packet
//   fifo_full       FIFO holds FIFO_DEPTH elements (registered)
//   drop_count      elements dropped on overflow, saturating
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_last hold stable. out_valid only falls after a transfer.
module trace_serialiser #(
   parameter int DATA_WIDTH = 32,
   parameter int ELEM_WIDTH = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           counter,
   input  logic                  elem_valid,
   input  logic [ELEM_WIDTH-1:0] elem_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  fifo_full,
   output logic [15:0]           drop_count
);

   localparam int W    = (ELEM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int PW   = W * DATA_WIDTH;
   localparam int IDXW = $clog2(W + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
`ifdef TRACE_SERIAL_CHECKSUM_EN
   localparam int HDR_LEN      = W + 1;
   localparam bit LAST_PAYLOAD = 1'b0;
`else
   localparam int HDR_LEN      = W;
   localparam bit LAST_PAYLOAD = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD
`ifdef TRACE_SERIAL_CHECKSUM_EN
      , S_CHECKSUM
`endif
   } state_t;

   state_t state_q, state_n;

   // Capture stage: tags the element in the strobe cycle, and pushes it into
   // the FIFO on the following edge.
   logic                  cap_valid;
   logic [ELEM_WIDTH-1:0] cap_elem;
   logic [7:0]            cap_seq, cap_cnt, seq_q;

   // Element FIFO. The head entry stays resident until its packet has been
   // fully accepted, so FIFO_DEPTH counts every element not yet delivered,
   // including the one currently in flight.
   logic [ELEM_WIDTH-1:0] mem_elem [FIFO_DEPTH];
   logic [7:0]            mem_seq  [FIFO_DEPTH];
   logic [7:0]            mem_cnt  [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr, nxt_ptr, start_ptr;
   logic [AW:0]           count_q, count_n;
   logic                  push_ok, drop, release_head;

   logic [PW-1:0]         shreg_q, shreg_n;
   logic [IDXW-1:0]       idx_q, idx_n;   // payload words driven so far
   logic                  ov_n, ol_n, start, finish, hs;
   logic [DATA_WIDTH-1:0] od_n;
`ifdef TRACE_SERIAL_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_n;
`endif

   logic unused_counter_hi;
   assign unused_counter_hi = ^counter[31:8];

   assign hs      = out_valid && out_ready;
   assign nxt_ptr = rd_ptr + AW'(1);

   // A push into a full FIFO succeeds only when the head is released in the
   // same edge.
   assign push_ok = cap_valid && ((count_q != (AW+1)'(FIFO_DEPTH)) || release_head);
   assign drop    = cap_valid && !push_ok;
   assign count_n = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, release_head};

   always_comb begin
      state_n      = state_q;
      ov_n         = out_valid;
      od_n         = out_data;
      ol_n         = out_last;
      shreg_n      = shreg_q;
      idx_n        = idx_q;
      release_head = 1'b0;
      start        = 1'b0;
      finish       = 1'b0;
      start_ptr    = rd_ptr;
`ifdef TRACE_SERIAL_CHECKSUM_EN
      csum_n       = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) start = 1'b1;
         end
         S_HEADER: begin
            if (hs) begin
               od_n    = shreg_q[DATA_WIDTH-1:0];
               shreg_n = shreg_q >> DATA_WIDTH;
               idx_n   = IDXW'(1);
               ol_n    = LAST_PAYLOAD && (W == 1);
`ifdef TRACE_SERIAL_CHECKSUM_EN
               csum_n  = csum_q ^ shreg_q[DATA_WIDTH-1:0];
`endif
               state_n = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (hs) begin
               if (idx_q == IDXW'(W)) begin
`ifdef TRACE_SERIAL_CHECKSUM_EN
                  od_n    = csum_q;
                  ol_n    = 1'b1;
                  state_n = S_CHECKSUM;
`else
                  finish  = 1'b1;
`endif
               end else begin
                  od_n    = shreg_q[DATA_WIDTH-1:0];
                  shreg_n = shreg_q >> DATA_WIDTH;
                  idx_n   = idx_q + IDXW'(1);
                  ol_n    = LAST_PAYLOAD && (idx_q == IDXW'(W - 1));
`ifdef TRACE_SERIAL_CHECKSUM_EN
                  csum_n  = csum_q ^ shreg_q[DATA_WIDTH-1:0];
`endif
               end
            end
         end
`ifdef TRACE_SERIAL_CHECKSUM_EN
         S_CHECKSUM: begin
            if (hs) finish = 1'b1;
         end
`endif
         default: state_n = S_IDLE;
      endcase

      // End of packet: free the head; if another element is already waiting
      // behind it, start that packet in the same edge (no bubble).
      if (finish) begin
         release_head = 1'b1;
         if (count_q > (AW+1)'(1)) begin
            start     = 1'b1;
            start_ptr = nxt_ptr;
         end else begin
            ov_n    = 1'b0;
            ol_n    = 1'b0;
            state_n = S_IDLE;
         end
      end

      if (start) begin
         ov_n    = 1'b1;
         od_n    = {8'hA5, mem_seq[start_ptr], 8'(HDR_LEN), mem_cnt[start_ptr]};
         ol_n    = 1'b0;
         shreg_n = PW'(mem_elem[start_ptr]);
         idx_n   = '0;
`ifdef TRACE_SERIAL_CHECKSUM_EN
         csum_n  = {8'hA5, mem_seq[start_ptr], 8'(HDR_LEN), mem_cnt[start_ptr]};
`endif
         state_n = S_HEADER;
      end
   end

   // FIFO storage carries no reset; the pointers define its contents.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_elem[wr_ptr] <= cap_elem;
         mem_seq[wr_ptr]  <= cap_seq;
         mem_cnt[wr_ptr]  <= cap_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         shreg_q    <= '0;
         idx_q      <= '0;
         cap_valid  <= 1'b0;
         cap_elem   <= '0;
         cap_seq    <= '0;
         cap_cnt    <= '0;
         seq_q      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         fifo_full  <= 1'b0;
         drop_count <= '0;
`ifdef TRACE_SERIAL_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q   <= state_n;
         out_valid <= ov_n;
         out_data  <= od_n;
         out_last  <= ol_n;
         shreg_q   <= shreg_n;
         idx_q     <= idx_n;
`ifdef TRACE_SERIAL_CHECKSUM_EN
         csum_q    <= csum_n;
`endif
         // The sequence number is consumed even if the element is later
         // dropped, so loss shows up as a gap downstream.
         cap_valid <= elem_valid;
         if (elem_valid) begin
            cap_elem <= elem_i;
            cap_seq  <= seq_q;
            cap_cnt  <= counter[7:0];
            seq_q    <= seq_q + 8'd1;
         end
         if (push_ok)      wr_ptr <= wr_ptr + AW'(1);
         if (release_head) rd_ptr <= nxt_ptr;
         count_q   <= count_n;
         fifo_full <= (count_n == (AW+1)'(FIFO_DEPTH));
         if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_trace_serialiser.sv
module tb_trace_serialiser;

   localparam int W  = 8;
`ifdef TRACE_SERIAL_CHECKSUM_EN
   localparam int HL = W + 1;
   localparam bit CS = 1'b1;
   localparam logic [31:0] HDR1 = 32'hA5000912;
`else
   localparam int HL = W;
   localparam bit CS = 1'b0;
   localparam logic [31:0] HDR1 = 32'hA5000812;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  counter = 32'd0;
   logic         elem_valid = 1'b0;
   logic [255:0] elem_i = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_data;
   logic         out_last;
   logic         fifo_full;
   logic [15:0]  drop_count;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   logic [7:0]  tb_seq = 8'd0;
   int hs_total = 0, cyc = 0, first_mark = -1, first_hs_cyc = 0, last_hs_cyc = 0;

   trace_serialiser dut (
      .clk(clk), .rst(rst), .counter(counter),
      .elem_valid(elem_valid), .elem_i(elem_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .fifo_full(fifo_full), .drop_count(drop_count)
   );

   // clock / free-running counter
   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      counter = counter + 32'd1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   logic        stalled = 1'b0;
   logic [32:0] held = '0;
   always @(negedge clk) begin
      logic [32:0] e;
      cyc++;
      if (!rst) begin
         if (stalled) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_word", 64'({out_last, out_data}), 64'(held));
         end
         stalled = out_valid && !out_ready;
         held    = {out_last, out_data};
         if (out_valid && out_ready) begin
            if (hs_total == first_mark) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_total++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
            end else begin
               e = exp_q.pop_front();
               chk("stream_word", 64'({out_last, out_data}), 64'(e));
            end
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [255:0] make_elem(input logic [31:0] base);
      logic [255:0] e;
      for (int k = 0; k < W; k++) e[32*k +: 32] = base + 32'(k);
      return e;
   endfunction

   task automatic push_packet(input logic [7:0] seq, input logic [7:0] cnt, input logic [255:0] e);
      logic [31:0] hdr, x, w;
      hdr = {8'hA5, seq, 8'(HL), cnt};
      x   = hdr;
      exp_q.push_back({1'b0, hdr});
      for (int k = 0; k < W; k++) begin
         w = e[32*k +: 32];
         x = x ^ w;
         exp_q.push_back({(k == W - 1) && !CS, w});
      end
      if (CS) exp_q.push_back({1'b1, x});
   endtask

   task automatic strobe(input logic [255:0] e, input bit kept);
      elem_valid = 1'b1;
      elem_i     = e;
      if (kept) push_packet(tb_seq, counter[7:0], e);
      tb_seq = tb_seq + 8'd1;
      tick();
      elem_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      tb_seq = 8'd0;
   endtask

   initial begin
      int n, h0;
      // reset state
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_fifo_full", 64'(fifo_full), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      rst = 1'b0;

      // single element at counter 0x12, latency N+2
      out_ready = 1'b1;
      n = 0;
      while (counter[7:0] != 8'h12 && n < 300) begin
         tick();
         n++;
      end
      strobe(make_elem(32'd1), 1'b1);
      @(negedge clk);
      chk("lat_edge_n", 64'(out_valid), 64'd0);
      tick();
      chk("lat_edge_n1", 64'(out_valid), 64'd0);
      tick();
      chk("lat_edge_n2", 64'(out_valid), 64'd1);
      chk("hdr_single", 64'(out_data), 64'(HDR1));
      wait_drain(40);

      // backpressure 1,0,0,1 during payload
      strobe(make_elem(32'h100), 1'b1);
      repeat (3) tick();
      out_ready = 1'b1; tick();
      out_ready = 1'b0; tick();
      tick();
      out_ready = 1'b1; tick();
      wait_drain(40);

      // overflow: six strobes with the sink stalled
      do_reset();
      out_ready = 1'b0;
      chk("ovf_not_full", 64'(fifo_full), 64'd0);
      for (int i = 0; i < 4; i++) strobe(make_elem(32'h1000 * (i + 1)), 1'b1);
      chk("ovf_full_before_push4", 64'(fifo_full), 64'd0);
      tick();
      chk("ovf_full_after_4", 64'(fifo_full), 64'd1);
      strobe(make_elem(32'h5000), 1'b0);
      strobe(make_elem(32'h6000), 1'b0);
      tick();
      tick();
      chk("ovf_drop_count", 64'(drop_count), 64'd2);
      chk("ovf_still_full", 64'(fifo_full), 64'd1);
      out_ready = 1'b1;
      wait_drain(100);
      chk("ovf_full_cleared", 64'(fifo_full), 64'd0);
      chk("ovf_next_seq_model", 64'(tb_seq), 64'd6);
      strobe(make_elem(32'h7000), 1'b1);
      wait_drain(40);
      chk("ovf_drop_final", 64'(drop_count), 64'd2);

      // back-to-back with sequence wrap
      do_reset();
      out_ready  = 1'b1;
      h0         = hs_total;
      first_mark = hs_total;
      for (int i = 0; i < 300; i++) begin
         strobe(make_elem(32'(i) << 16), 1'b1);
         repeat (HL) tick();
      end
      wait_drain(200);
      chk("b2b_words", 64'(hs_total - h0), 64'(300 * (HL + 1)));
      chk("b2b_no_bubbles", 64'(last_hs_cyc - first_hs_cyc + 1), 64'(300 * (HL + 1)));
      chk("b2b_drop_count", 64'(drop_count), 64'd0);

      // reset during payload word 3, with a second element queued
      h0 = hs_total;
      strobe(make_elem(32'h9000), 1'b1);
      tick();
      strobe(make_elem(32'hA000), 1'b1);
      n = 0;
      while (hs_total < h0 + 4 && n < 50) begin
         tick();
         n++;
      end
      chk("mid_reached_word3", 64'(hs_total - h0), 64'd4);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_full", 64'(fifo_full), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      tb_seq = 8'd0;
      repeat (4) tick();
      chk("mid_fifo_empty", 64'(out_valid), 64'd0);
      strobe(make_elem(32'hB000), 1'b1);
      wait_drain(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_serialiser.md
# trace_serialiser

Terminal stage of the trace pipeline, directly downstream of the WB tracker. Captures each completed trace element (packed `trace_output`) on a one-cycle strobe and buffers it in a small FIFO. Emits it as a framed stream of 32-bit words (header + payload) over a valid/ready handshake towards the trace sink. There is no backpressure to the WB tracker: overflow drops elements and counts them.

## Interface
- `DATA_WIDTH`, default 32: output word width; fixed at 32.
- `ELEM_WIDTH`, default 256: packed width of `trace_output`. Payload words `W = ceil(ELEM_WIDTH/32)`; the top word is zero-padded in its MSBs.
- `FIFO_DEPTH`, default 4: element FIFO depth; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `counter`, in, 32 (integer): global cycle counter.
- `elem_valid`, in, 1: one-cycle strobe; `elem_i` holds a new element.
- `elem_i`, in, ELEM_WIDTH: packed trace element from the WB tracker.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: sink accepts the word when high together with `out_valid`.
- `out_data`, out, 32: stream word.
- `out_last`, out, 1: final word of the current packet.
- `fifo_full`, out, 1: FIFO holds FIFO_DEPTH elements.
- `drop_count`, out, 16: elements dropped on overflow; saturates at 16'hFFFF.

## Operation
- **Capture.** When `elem_valid` is sampled high, the element is stored with:
  - the current 8-bit sequence number (then incremented, wrapping 255→0);
  - `counter[7:0]`.
- **Overflow.**
  - If the FIFO is full and no pop happens in the same cycle, the element is discarded and `drop_count` increments.
  - The sequence number is still consumed, so the gap is visible downstream.
  - A simultaneous push and pop on a full FIFO accepts the push.
- **Packet format.**
  - Header word: [31:24]=8'hA5, [23:16]=seq, [15:8]=words following the header, [7:0]=captured `counter[7:0]`.
  - Payload words follow, `elem_i[31:0]` first, ascending.
  - `out_last` is asserted on the final word only.
- **FSM states:** IDLE, HEADER, PAYLOAD, CHECKSUM (CHECKSUM exists only when the configuration macro is defined).
  - IDLE: if the FIFO is non-empty, pop into the shift register, drive the header, go to HEADER.
  - HEADER: on handshake, drive payload word 0, go to PAYLOAD.
  - PAYLOAD: on each handshake, advance the word index. On acceptance of word W-1:
    - go to CHECKSUM if enabled;
    - otherwise, if the FIFO is non-empty, pop and drive the next header in the same edge (stay in HEADER);
    - otherwise go to IDLE.
  - CHECKSUM: on handshake, the same next-packet-or-IDLE rule applies.
- **Output stability.** While `out_valid && !out_ready`, `out_data` and `out_last` hold stable. `out_valid` never drops without a handshake.
- **Word index counter** width is `$clog2(W+1)`. Word count in the header is W, or W+1 with the checksum.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_last`=0;
  - `fifo_full`=0, `drop_count`=0;
  - FIFO empty, sequence number 0, FSM in IDLE.
- **Reset mid-packet.** The packet is abandoned, with no further words. `out_valid` is low in the cycle after `rst` is sampled high.
- **Latency.**
  - `elem_valid` sampled at edge N, FIFO empty and FSM in IDLE: header has `out_valid` high after edge N+2.
  - With `out_ready` held high, a packet occupies W+1 consecutive cycles (W+2 with checksum).
  - Back-to-back packets have zero bubble cycles.
- **Sustained throughput.** Input may strobe at most one element per W+1 cycles without loss when `out_ready`=1.
- **`fifo_full`** is registered and reflects occupancy after the current edge's push/pop.

## Configuration
- **Macro:** `TRACE_SERIAL_CHECKSUM_EN`.
- **Defined:** each packet gains a trailing checksum word, equal to the XOR of the header and all W payload words. `out_last` moves to the checksum word. Header [15:8]=W+1.
- **Undefined:** there is no CHECKSUM state, `out_last` is on payload word W-1, and header [15:8]=W.

## Test plan
- **Single element.** Defaults, `out_ready`=1, `elem_valid` pulse at counter=0x12 with `elem_i`=word k = k+1.
  - Expect header 0xA5_00_08_12 two cycles later, then 1..8.
  - `out_last` is on word 8.
- **Backpressure.** `out_ready` is toggled 1,0,0,1 during payload. Expect no duplicated or skipped words and `out_data` stable during stalls.
- **Overflow.** `out_ready`=0, six strobes.
  - `fifo_full`=1 after the 4th strobe; `drop_count`=2.
  - After releasing `out_ready`, expect 4 packets with seq 0,1,2,3 and the next accepted element at seq 6.
- **Back-to-back and wrap.** 300 elements spaced W+1 cycles apart with `out_ready`=1.
  - Zero idle cycles between packets; seq goes 255→0; `drop_count`=0.
- **Reset mid-packet.** `rst` asserted during payload word 3.
  - Next cycle `out_valid`=0; FIFO empty; the next element emits header seq 0.
- **Checksum.** With `TRACE_SERIAL_CHECKSUM_EN` and the single-element stimulus:
  - header [15:8]=9;
  - 10th word = 0xA5000912 ^ 1 ^ 2 ^ … ^ 8 = 0xA5000912 ^ 8 = 0xA500091A, with `out_last`=1.
